// File: rtl/mux_nto1_pkg.sv
// mux_nto1_pkg -- shared types and helpers for the N:1 registered multiplexer.
//   state_t     : controller states (IDLE, SCAN, STALL)
//   sel_width() : select width for an N-channel mux (at least 1 bit)
//   MODE_*      : encodings of the mode input
package mux_nto1_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      STALL = 2'd2
   } state_t;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// mux_scan_ctr -- dwell counter plus wrapping channel pointer for scan mode.
//   clk, rst : clock, synchronous active-high reset (ptr=0, count=0)
//   en       : counting active this cycle
//   freeze   : hold counter and pointer even though en is high
//   clr      : clear the dwell counter (pointer keeps its value)
//   ptr      : channel currently being dwelt on
//   terminal : the dwell counter has reached DWELL-1
// On an enabled, unfrozen terminal cycle the counter clears and the pointer
// advances, wrapping from N-1 to 0.
module mux_scan_ctr
   import mux_nto1_pkg::*;
#(
   parameter  int N     = 16,
   parameter  int DWELL = 4,
   localparam int SELW  = sel_width(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            freeze,
   input  logic            clr,
   output logic [SELW-1:0] ptr,
   output logic            terminal
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
   localparam logic [SELW-1:0] PTR_LAST = SELW'(N - 1);

   logic [CW-1:0] cnt;

   assign terminal = (cnt == CNT_LAST);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         ptr <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !freeze) begin
         if (terminal) begin
            cnt <= '0;
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_nto1_seq.sv
// mux_nto1_seq -- N-channel, W-bit registered multiplexer with valid/ready output.
//   clk, rst       : clock, synchronous active-high reset
//   in_bus         : N flattened channels, channel k at in_bus[k*W +: W]
//   mode           : 0 = manual select, 1 = round-robin scan
//   sel, sel_load  : manual channel request (dropped if sel >= N or !sel_ready)
//   sel_ready      : a manual request can be accepted this cycle
//   out_data/out_ch/out_valid, out_ready : registered output stream
// Optional (macro MUX_PARITY_EN):
//   out_par        : registered XOR of out_data
//   in_par_err_inj : invert the stored parity on the capturing cycle
module mux_nto1_seq
   import mux_nto1_pkg::*;
#(
   parameter  int N     = 16,
   parameter  int W     = 8,
   parameter  int DWELL = 4,
   localparam int SELW  = sel_width(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  in_bus,
   input  logic            mode,
   input  logic [SELW-1:0] sel,
   input  logic            sel_load,
   output logic            sel_ready,
   output logic [W-1:0]    out_data,
   output logic [SELW-1:0] out_ch,
   output logic            out_valid,
   input  logic            out_ready
`ifdef MUX_PARITY_EN
   ,
   output logic            out_par,
   input  logic            in_par_err_inj
`endif
);

   localparam int NSLOT = 2 ** SELW;
   localparam logic [SELW:0] SEL_LIMIT = (SELW + 1)'(N);

   state_t          state, state_nxt;
   logic            permit, sel_ok;
   logic            cap_manual, cap_scan, capture;
   logic            ctr_en, ctr_clr, ctr_freeze, terminal;
   logic [SELW-1:0] ptr, cap_idx;
   logic [W-1:0]    cap_data;
   logic [W-1:0]    chan [NSLOT];

   // Unpack into a power-of-two array so any select value indexes in range;
   // the unused slots are never captured because sel_ok filters them.
   for (genvar k = 0; k < NSLOT; k++) begin : g_chan
      if (k < N) begin : g_used
         assign chan[k] = in_bus[k*W +: W];
      end else begin : g_pad
         assign chan[k] = '0;
      end
   end

   assign permit    = !out_valid || out_ready;
   assign sel_ready = permit;
   assign sel_ok    = ({1'b0, sel} < SEL_LIMIT);
   assign capture   = cap_manual || cap_scan;
   assign cap_idx   = (state == IDLE) ? sel : ptr;
   assign cap_data  = chan[cap_idx];
   // Only a terminal cycle that cannot capture freezes; in STALL the counter
   // sits at its terminal value, so this also holds it there.
   assign ctr_freeze = terminal && !permit;

   mux_scan_ctr #(.N(N), .DWELL(DWELL)) u_scan_ctr (
      .clk      (clk),
      .rst      (rst),
      .en       (ctr_en),
      .freeze   (ctr_freeze),
      .clr      (ctr_clr),
      .ptr      (ptr),
      .terminal (terminal)
   );

   // NOTE: every signal driven here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt  = state;
      cap_manual = 1'b0;
      cap_scan   = 1'b0;
      ctr_en     = 1'b0;
      ctr_clr    = 1'b0;
      unique case (state)
         IDLE: begin
            ctr_clr = 1'b1;
            if (mode == MODE_SCAN) begin
               state_nxt = SCAN;
            end else if (sel_load && permit && sel_ok) begin
               cap_manual = 1'b1;
            end
         end
         SCAN: begin
            if (mode == MODE_MANUAL) begin
               state_nxt = IDLE;
            end else begin
               ctr_en = 1'b1;
               if (terminal) begin
                  if (permit) cap_scan  = 1'b1;
                  else        state_nxt = STALL;
               end
            end
         end
         STALL: begin
            if (mode == MODE_MANUAL) begin
               state_nxt = IDLE;
            end else begin
               ctr_en = 1'b1;
               if (permit) begin
                  cap_scan  = 1'b1;
                  state_nxt = SCAN;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: reset is synchronous, so rst is just the highest-priority branch
   // inside the clocked block; no reset term appears in the sensitivity list.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            out_data  <= cap_data;
            out_ch    <= cap_idx;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef MUX_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst)          out_par <= 1'b0;
      else if (capture) out_par <= (^cap_data) ^ in_par_err_inj;
   end
`endif

endmodule

// File: tb/tb_mux_nto1_seq.sv
// tb_mux_nto1_seq -- directed plus randomized bench for mux_nto1_seq against a
// transaction-level reference model (N=12 so out-of-range selects exist).
module tb_mux_nto1_seq;
   import mux_nto1_pkg::*;

   localparam int N     = 12;
   localparam int W     = 8;
   localparam int DWELL = 4;
   localparam int SELW  = sel_width(N);

   logic            clk = 1'b0;
   logic            rst, mode, sel_load, out_ready;
   logic            sel_ready, out_valid;
   logic [N*W-1:0]  in_bus;
   logic [SELW-1:0] sel, out_ch;
   logic [W-1:0]    out_data;
`ifdef MUX_PARITY_EN
   logic            out_par, in_par_err_inj;
`endif

   always #5 clk = ~clk;

   mux_nto1_seq #(.N(N), .W(W), .DWELL(DWELL)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_bus    (in_bus),
      .mode      (mode),
      .sel       (sel),
      .sel_load  (sel_load),
      .sel_ready (sel_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef MUX_PARITY_EN
      ,
      .out_par        (out_par),
      .in_par_err_inj (in_par_err_inj)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: an output slot plus a scan position (channel, cycles
   // dwelt) and a "waiting to sample" flag.
   bit          m_valid;
   logic [W-1:0] m_data;
   int          m_ch;
   bit          m_scanning, m_waiting;
   int          m_ptr, m_dwelt;
   int          n_beats;

   function automatic logic [W-1:0] chan_val(input int k);
      return in_bus[k*W +: W];
   endfunction

   task automatic model_edge();
      bit can_take, take;
      int pick;
      if (rst) begin
         m_valid = 0; m_data = '0; m_ch = 0;
         m_scanning = 0; m_waiting = 0; m_ptr = 0; m_dwelt = 0;
         return;
      end
      can_take = !m_valid || out_ready;
      take = 0;
      pick = 0;
      if (!m_scanning) begin
         if (mode) begin
            m_scanning = 1; m_dwelt = 0;
         end else if (sel_load && can_take && int'(sel) < N) begin
            take = 1; pick = int'(sel);
         end
      end else if (!mode) begin
         m_scanning = 0; m_waiting = 0;
      end else if (m_waiting || m_dwelt == DWELL - 1) begin
         if (can_take) begin
            take = 1; pick = m_ptr;
            m_ptr = (m_ptr + 1) % N;
            m_dwelt = 0; m_waiting = 0;
         end else begin
            m_waiting = 1;
         end
      end else begin
         m_dwelt++;
      end
      if (take) begin
         m_valid = 1; m_data = chan_val(pick); m_ch = pick;
         n_beats++;
      end else if (out_ready) begin
         m_valid = 0;
      end
   endtask

   // One clock: check sel_ready before the edge, advance the model, then
   // compare the registered outputs shortly after the edge.
   task automatic step();
      bit was_rst;
      #1;
      was_rst = rst;
      if (!rst) check("sel_ready", sel_ready, !m_valid || out_ready);
      model_edge();
      @(posedge clk);
      #1;
      check("out_valid", out_valid, m_valid);
      if (m_valid || was_rst) begin
         check("out_data", out_data, m_data);
         check("out_ch", out_ch, m_ch);
`ifdef MUX_PARITY_EN
         check("out_par", out_par, was_rst ? 1'b0 : ^m_data);
`endif
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int beats0;
      rst = 1; mode = 0; sel = '0; sel_load = 0; out_ready = 1;
      in_bus = '1;
`ifdef MUX_PARITY_EN
      in_par_err_inj = 0;
`endif
      @(negedge clk);

      // Reset with all-ones inputs.
      steps(2);
      rst = 0;
      check("rst_valid", out_valid, 1'b0);
      check("rst_data", out_data, '0);
      check("rst_ch", out_ch, '0);

      // Manual select of channel 5.
      for (int k = 0; k < N; k++) in_bus[k*W +: W] = W'($urandom);
      in_bus[5*W +: W] = 8'hA5;
      sel = 4'd5; sel_load = 1;
      step();
      check("man_data", out_data, 8'hA5);
      check("man_ch", out_ch, 4'd5);
      sel_load = 0;
      step();
      check("man_drop", out_valid, 1'b0);

      // Backpressure: beat held, second request refused while stalled.
      out_ready = 0; sel_load = 1;
      step();
      sel = 4'd7;
      steps(3);
      #1;
      check("bp_ready", sel_ready, 1'b0);
      check("bp_hold", out_data, 8'hA5);
      out_ready = 1;
      step();
      check("bp_ch7", out_ch, 4'd7);
      sel_load = 0;
      step();

      // Out-of-range select produces nothing.
      sel = 4'd13; sel_load = 1;
      steps(3);
      check("illegal", out_valid, 1'b0);
      sel_load = 0;

      // Scan across two full wraps with the consumer always ready.
      mode = 1;
      beats0 = n_beats;
      steps(2 * N * DWELL + 1);
      check("scan_beats", n_beats - beats0, 2 * N);

      // Stall the consumer for 10 cycles mid-scan, then release.
      steps(2);
      out_ready = 0;
      beats0 = n_beats;
      steps(10);
      check("stall_beats", n_beats - beats0, 1);
      out_ready = 1;
      steps(3 * DWELL);

      // Abort scan mid-dwell.
      steps(1);
      mode = 0;
      step();
      beats0 = n_beats;
      steps(3 * DWELL);
      check("abort_beats", n_beats - beats0, 0);
      check("abort_valid", out_valid, 1'b0);

      // Randomized traffic.
      for (int c = 0; c < 600; c++) begin
         rst       = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         sel       = SELW'($urandom_range(0, 15));
         sel_load  = $urandom_range(0, 1) == 1;
         out_ready = $urandom_range(0, 3) != 0;
         in_bus[$urandom_range(0, N-1)*W +: W] = W'($urandom);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_nto1_seq.md
Name: mux_nto1_seq

Overview:
- Parametrised N-channel, W-bit registered multiplexer. It is the sequential successor of the team's fixed 16:1 bit mux.
- Supports two selection modes:
  - Manual: a select value is loaded with a handshake.
  - Scan: the block auto-scans the channels round-robin with a programmable dwell.
- Output is a registered valid/ready stream. The block sits between parallel sensor/status buses and a single serial consumer.

Parameters:
- N, 16, number of input channels (N >= 2).
- W, 8, bits per channel.
- DWELL, 4, cycles spent on each channel in scan mode before sampling (DWELL >= 1).
- SELW (localparam), clog2(N), select width.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_bus, input, N*W, flattened channels; channel k is in_bus[k*W +: W].
- mode, input, 1, 0 = manual, 1 = scan.
- sel, input, SELW, manual channel index.
- sel_load, input, 1, manual select request.
- sel_ready, output, 1, high when a manual request can be accepted (combinational: !out_valid || out_ready).
- out_data, output, W, sampled channel data.
- out_ch, output, SELW, index of the channel in out_data.
- out_valid, output, 1, output beat valid.
- out_ready, input, 1, consumer accepts the beat.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_data=0, out_ch=0, out_valid=0.
  - scan pointer=0, dwell counter=0, FSM=IDLE.
  - Reset mid-scan or mid-stall discards the pending beat.
- Output register:
  - A beat is "accepted" when out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_ch and out_valid are held stable.
  - A new capture is permitted when !out_valid || out_ready, so sustained throughput is 1 beat/cycle.
- Manual mode (mode=0, FSM IDLE):
  - If sel_load && sel_ready && sel<N at edge t, then at t+1: out_data=in_bus[sel] as sampled at t, out_ch=sel, out_valid=1. Latency is 1 cycle.
  - sel >= N: request dropped, no beat, state unchanged.
  - sel_load with sel_ready=0: dropped; the requester must hold the request until sel_ready is high.
- Scan mode FSM states: IDLE, SCAN, STALL.
  - IDLE -> SCAN when mode=1. The dwell counter clears to 0 and the pointer keeps its value.
  - In SCAN, the counter increments each cycle. When counter==DWELL-1, the block samples channel[pointer].
    - If capture is permitted: beat issued, pointer advances (N-1 wraps to 0), counter clears.
    - Otherwise the FSM goes to STALL.
  - In STALL, the counter and pointer are frozen. When capture becomes permitted, the channel is sampled then (in_bus value at that edge) and the FSM returns to SCAN.
  - mode=0 in SCAN or STALL: next state is IDLE and the pointer is retained. An already-issued beat stays until accepted. A pending STALL sample is abandoned.
  - sel_load is ignored whenever mode=1.
- Scan cadence with out_ready held high: one beat every DWELL cycles. The channel sequence is 0,1,...,N-1,0,...

Optional Feature:
- Macro: MUX_PARITY_EN.
- When defined:
  - Extra output port out_par (1 bit) = XOR of out_data. It is registered together with out_data, reset to 0 and held during stalls.
  - Extra input port in_par_err_inj (1 bit): when high at capture, the stored out_par is inverted.
- When undefined: neither port exists and there is no parity logic.

Decomposition:
- Package mux_nto1_pkg holds:
  - state typedef {IDLE, SCAN, STALL}.
  - a clog2-based select-width function.
  - the MODE_MANUAL/MODE_SCAN constants.
- One natural sub-module, mux_scan_ctr. It contains the dwell counter and the wrapping channel pointer, with inputs en/freeze/clr and outputs ptr/terminal.
- The top module holds the FSM, the capture/output register and the slice select.

Test Plan:
- Reset: assert rst for 2 cycles with in_bus all-ones. Expect out_valid=0, out_data=0, out_ch=0 after reset.
- Manual: N=16, W=8, channel 5 = 8'hA5, sel=5, sel_load 1 cycle, out_ready=1. Expect at t+1 out_data=A5, out_ch=5, out_valid=1; valid drops at t+2.
- Backpressure: hold out_ready=0 after the manual beat, then issue sel_load with sel=7. Expect sel_ready=0, out_data held at A5, request dropped. Raise out_ready and reissue: expect beat with out_ch=7.
- Illegal select: N=12, sel=13. Expect no beat and out_valid stays 0.
- Scan wrap: mode=1, DWELL=4, N=4, out_ready=1. Expect beats every 4 cycles with out_ch 0,1,2,3,0.
- Scan stall and abort:
  - Drop out_ready for 10 cycles during scan. Expect exactly one held beat, pointer frozen, sampling resumes on release.
  - Then set mode=0 mid-dwell. Expect IDLE within 1 cycle and no further beats.
